imm_ext_pipe: RTL and testbench

- Parametrised, pipelined immediate extender for the CPU datapath. It takes an IN_W-bit instruction immediate plus a 2-bit mode, and produces an OUT_W-bit extended or shifted immediate.
- It sits between decode and the ALU/branch-adder operand muxes.
- It uses a valid/ready handshake with a 2-entry skid buffer, so it can run at full throughput with no combinational ready path from ready_i to ready_o.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/imm_ext_core.sv | 38 +++
 rtl/imm_ext_pipe.sv | 94 +++++++++
 tb/tb_imm_ext_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`timescale 1ns/1ps
// Shared datapath constants: immediate extension modes and the skid-buffer state encoding.
package cpu_pkg;

    localparam logic [1:0] EXT_SIGN   = 2'd0;
    localparam logic [1:0] EXT_ZERO   = 2'd1;
    localparam logic [1:0] EXT_HIGH   = 2'd2;
    localparam logic [1:0] EXT_BRANCH = 2'd3;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/imm_ext_core.sv
`timescale 1ns/1ps
// Immediate extender: sign/zero/high (LUI) or sign-extended-and-shifted branch offset.
// Latency: purely combinational.
// Backpressure: none; the enclosing pipe owns the handshake.
module imm_ext_core
    import cpu_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2
) (
    input  logic [IN_W-1:0]  data_i,
    input  logic [1:0]       mode_i,
    output logic [OUT_W-1:0] data_o
);

    logic [OUT_W-1:0] ext_sign;
    logic [OUT_W-1:0] ext_zero;
    logic [OUT_W-1:0] ext_high;
    logic [OUT_W-1:0] ext_branch;

    assign ext_sign   = OUT_W'(signed'(data_i));
    assign ext_zero   = OUT_W'(data_i);
    assign ext_high   = ext_zero << (OUT_W - IN_W);
    assign ext_branch = ext_sign << SHIFT;

    always_comb begin
        data_o = ext_sign;
        case (mode_i)
            EXT_SIGN:   data_o = ext_sign;
            EXT_ZERO:   data_o = ext_zero;
            EXT_HIGH:   data_o = ext_high;
            EXT_BRANCH: data_o = ext_branch;
            default:    data_o = ext_sign;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
`timescale 1ns/1ps
// Pipelined immediate extender with a 2-entry skid buffer between decode and the operand muxes.
// Latency: 1 cycle accept-to-valid_o; full throughput while ready_i stays high.
// Backpressure: ready_o comes from registered state only and drops once both entries are held.
module imm_ext_pipe
    import cpu_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IN_W-1:0]  data_i,
    input  logic [1:0]       mode_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [OUT_W-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i
);

    if ((OUT_W < IN_W + SHIFT) || (IN_W < 2)) begin : g_param_err
        $error("imm_ext_pipe: need OUT_W >= IN_W + SHIFT and IN_W >= 2");
    end

    state_e           state_q, state_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [OUT_W-1:0] skid_q, skid_d;
    logic [OUT_W-1:0] ext_w;
    logic             accept;
    logic             pop;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_core (
        .data_i (data_i),
        .mode_i (mode_i),
        .data_o (ext_w)
    );

    assign ready_o = (state_q != ST_FULL);
    assign valid_o = (state_q != ST_EMPTY);
    assign data_o  = out_q;
    assign accept  = valid_i && ready_o;
    assign pop     = valid_o && ready_i;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    out_d   = ext_w;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    out_d = ext_w;
                end else if (accept) begin
                    state_d = ST_FULL;
                    skid_d  = ext_w;
                end else if (pop) begin
                    // data_o deliberately keeps the last word while idle
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_d = ST_ONE;
                    out_d   = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
`timescale 1ns/1ps
// Bench for imm_ext_pipe: queue-based reference model checked every cycle plus directed vectors.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v_i, rdy_i, ready_o, valid_o;
    logic [15:0] d_i;
    logic [1:0]  m_i;
    logic [31:0] data_o;
    logic        v8_i, rdy8_i, r8_o, v8_o;
    logic [7:0]  d8_i;
    logic [1:0]  m8_i;
    logic [15:0] d8_o;

    int     errors = 0;
    int     checks = 0;
    longint q[$];
    longint last_out = 0;
    longint acc_val = 0;
    bit     acc_f = 1'b0;
    bit     pop_f = 1'b0;
    int     pop_cnt = 0;

    logic [15:0] t1_d [0:4] = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF, 16'h7FFF};
    logic [1:0]  t1_m [0:4] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    logic [31:0] t1_e [0:4] = '{32'hFFFF8001, 32'h00008001, 32'h12340000, 32'hFFFFFFFC, 32'h0001FFFC};
    logic [7:0]  t6_d [0:2] = '{8'h80, 8'h80, 8'h12};
    logic [1:0]  t6_m [0:2] = '{2'd0, 2'd3, 2'd2};
    logic [15:0] t6_e [0:2] = '{16'hFF80, 16'hFF00, 16'h1200};

    always #5 clk = ~clk;

    imm_ext_pipe #(.IN_W(16), .OUT_W(32), .SHIFT(2)) dut (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .data_i  (d_i),
        .mode_i  (m_i),
        .valid_i (v_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (rdy_i)
    );

    imm_ext_pipe #(.IN_W(8), .OUT_W(16), .SHIFT(1)) dut8 (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .data_i  (d8_i),
        .mode_i  (m8_i),
        .valid_i (v8_i),
        .ready_o (r8_o),
        .data_o  (d8_o),
        .valid_o (v8_o),
        .ready_i (rdy8_i)
    );

    // Arithmetic reference: interpret the immediate as a signed/unsigned number and scale it.
    function automatic longint model_ext(input longint d, input int m, input int inw,
                                         input int outw, input int sh);
        longint sv, r, mask;
        mask = (longint'(1) << outw) - 1;
        sv   = (d >= (longint'(1) << (inw - 1))) ? d - (longint'(1) << inw) : d;
        case (m)
            0:       r = sv;
            1:       r = d;
            2:       r = d * (longint'(1) << (outw - inw));
            default: r = sv * (longint'(1) << sh);
        endcase
        return r & mask;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: a FIFO of at most two extended words; outputs follow from its occupancy.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_valid", longint'(valid_o), 0);
            check("rst_ready", longint'(ready_o), 1);
            check("rst_data", longint'(data_o), 0);
            q.delete();
            last_out = 0;
            acc_f = 1'b0;
            pop_f = 1'b0;
        end else begin
            check("cmp_valid", longint'(valid_o), longint'(q.size() != 0));
            check("cmp_ready", longint'(ready_o), longint'(q.size() < 2));
            check("cmp_data", longint'(data_o), (q.size() != 0) ? q[0] : last_out);
            acc_f   = v_i && (q.size() < 2);
            pop_f   = (q.size() != 0) && rdy_i;
            acc_val = model_ext(longint'(d_i), int'(m_i), 16, 32, 2);
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (pop_f && q.size() != 0) begin
                last_out = q.pop_front();
                pop_cnt++;
            end
            if (acc_f) q.push_back(acc_val);
        end
        acc_f = 1'b0;
        pop_f = 1'b0;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit took;
        int base;
        rst_n = 1'b0; v_i = 1'b0; rdy_i = 1'b0; d_i = '0; m_i = '0;
        v8_i = 1'b0; rdy8_i = 1'b0; d8_i = '0; m8_i = '0;

        check("pin_sign", model_ext(64'h8001, 0, 16, 32, 2), 64'hFFFF8001);
        check("pin_branch", model_ext(64'h7FFF, 3, 16, 32, 2), 64'h0001FFFC);
        check("pin_high8", model_ext(64'h12, 2, 8, 16, 1), 64'h1200);

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", longint'(ready_o), 1);
        check("reset_valid", longint'(valid_o), 0);
        check("reset_data", longint'(data_o), 0);
        check("reset8_valid", longint'(v8_o), 0);
        rst_n = 1'b1;

        // Mode coverage, one word per cycle
        rdy_i = 1'b1; v_i = 1'b1; d_i = t1_d[0]; m_i = t1_m[0];
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("t1_data%0d", i), longint'(data_o), longint'(t1_e[i]));
            check("t1_ready", longint'(ready_o), 1);
            check("t1_valid", longint'(valid_o), 1);
            if (i < 4) begin
                d_i = t1_d[i+1]; m_i = t1_m[i+1];
            end else begin
                v_i = 1'b0;
            end
        end
        repeat (2) @(posedge clk);

        // Backpressure: A, B buffered, C held upstream
        #1; rdy_i = 1'b0; v_i = 1'b1; d_i = 16'h0001; m_i = 2'd0;
        @(posedge clk); #1;
        check("t2_a_data", longint'(data_o), 1);
        check("t2_a_ready", longint'(ready_o), 1);
        d_i = 16'h0002;
        @(posedge clk); #1;
        check("t2_full_ready", longint'(ready_o), 0);
        d_i = 16'h0003;
        repeat (2) @(posedge clk); #1;
        check("t2_hold_data", longint'(data_o), 1);
        check("t2_hold_ready", longint'(ready_o), 0);
        rdy_i = 1'b1;
        @(posedge clk); #1;
        check("t2_pop_b", longint'(data_o), 2);
        @(posedge clk); #1;
        check("t2_pop_c", longint'(data_o), 3);
        v_i = 1'b0;
        @(posedge clk); #1;
        check("t2_empty_valid", longint'(valid_o), 0);
        check("t2_empty_data", longint'(data_o), 3);

        // Streaming 20 words with mixed modes
        base = pop_cnt;
        v_i = 1'b1; d_i = 16'h0100; m_i = 2'd0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("t3_valid", longint'(valid_o), 1);
            check("t3_ready", longint'(ready_o), 1);
            if (i < 19) begin
                d_i = 16'h0100 + 16'(i + 1); m_i = 2'((i + 1) % 4);
            end else begin
                v_i = 1'b0;
            end
        end
        @(posedge clk); #1;
        check("t3_pops", longint'(pop_cnt - base), 20);

        // Random handshakes; upstream keeps a word stable until it is taken
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            took = v_i && ready_o;
            @(posedge clk); #1;
            if (!v_i || took) begin
                v_i = ($urandom_range(0, 3) != 0);
                d_i = 16'($urandom);
                m_i = 2'($urandom_range(0, 3));
            end
            rdy_i = ($urandom_range(0, 3) != 0);
        end
        v_i = 1'b0; rdy_i = 1'b1;
        repeat (4) @(posedge clk); #1;
        check("t4_drained", longint'(q.size()), 0);

        // Reset while FULL discards both buffered words
        rdy_i = 1'b0; v_i = 1'b1; d_i = 16'hAAAA; m_i = 2'd0;
        @(posedge clk); #1;
        d_i = 16'hBBBB;
        @(posedge clk); #1;
        v_i = 1'b0;
        check("t5_full", longint'(ready_o), 0);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_valid", longint'(valid_o), 0);
        check("t5_rst_data", longint'(data_o), 0);
        check("t5_rst_ready", longint'(ready_o), 1);
        @(posedge clk); #1;
        rst_n = 1'b1; rdy_i = 1'b1; v_i = 1'b1; d_i = 16'h00FF; m_i = 2'd1;
        @(posedge clk); #1;
        v_i = 1'b0;
        check("t5_after_data", longint'(data_o), 32'h000000FF);
        check("t5_after_valid", longint'(valid_o), 1);
        @(posedge clk); #1;
        check("t5_idle_valid", longint'(valid_o), 0);

        // Narrow parameter variant
        rdy8_i = 1'b1; v8_i = 1'b1; d8_i = t6_d[0]; m8_i = t6_m[0];
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("t6_data%0d", i), longint'(d8_o), longint'(t6_e[i]));
            check($sformatf("t6_model%0d", i), longint'(d8_o),
                  model_ext(longint'(t6_d[i]), int'(t6_m[i]), 8, 16, 1));
            check("t6_valid", longint'(v8_o), 1);
            if (i < 2) begin
                d8_i = t6_d[i+1]; m8_i = t6_m[i+1];
            end else begin
                v8_i = 1'b0;
            end
        end
        @(posedge clk); #1;
        check("t6_idle_valid", longint'(v8_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
